// File: rtl/case_9_pkg.sv
// Shared constants, FSM state type and saturation bounds for the case_9 product accumulator.
// Bounds are returned as int and size-cast at the point of use.
package case_9_pkg;

    localparam int DEF_DIN_WIDTH = 10;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_FRAME_LEN = 8;
    localparam int DEF_CNT_WIDTH = 4;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    function automatic int sat_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/case_9_prod_accum_if.sv
// Product-in / frame-sum-out handshake bundle; slave is the accumulator's view, master the producer/consumer side.
// Both handshakes are valid/ready; prod_rdy and sum_vld are driven by the slave.
interface case_9_prod_accum_if #(
    parameter int DIN_WIDTH = 10,
    parameter int ACC_WIDTH = 16
);
    logic [DIN_WIDTH-1:0] prod_din;
    logic                 prod_vld;
    logic                 prod_rdy;
    logic [ACC_WIDTH-1:0] sum_dout;
    logic                 sum_vld;
    logic                 sum_rdy;
    logic                 sum_sat;
    logic                 busy;

    modport slave (
        input  prod_din, prod_vld, sum_rdy,
        output prod_rdy, sum_dout, sum_vld, sum_sat, busy
    );

    modport master (
        output prod_din, prod_vld, sum_rdy,
        input  prod_rdy, sum_dout, sum_vld, sum_sat, busy
    );
endinterface

// File: rtl/case_9_sat_add.sv
// Combinational signed accumulate step: acc + sign-extended product, clamped to the accumulator range.
// Zero latency, no flow control; sat flags that a clamp happened.
module case_9_sat_add
    import case_9_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [DIN_WIDTH-1:0] din,
    output logic signed [ACC_WIDTH-1:0] sum,
    output logic                        sat
);
    localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH:0] MIN_V = (ACC_WIDTH+1)'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] full;

    always_comb begin
        // One guard bit is enough: |din| never exceeds the accumulator range.
        full = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(din);
        sum  = full[ACC_WIDTH-1:0];
        sat  = 1'b0;
        if (full > MAX_V) begin
            sum = MAX_V[ACC_WIDTH-1:0];
            sat = 1'b1;
        end else if (full < MIN_V) begin
            sum = MIN_V[ACC_WIDTH-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/case_9_prod_accum.sv
// Sums FRAME_LEN signed products with saturation and presents each frame sum; sum_vld rises the cycle after the last accept.
// While a sum waits, prod_rdy follows sum_rdy, so a taken sum and the first product of the next frame overlap without a bubble.
module case_9_prod_accum
    import case_9_pkg::*;
#(
    parameter int DIN_WIDTH = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    case_9_prod_accum_if.slave   bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_i;

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                        sat_flag_q, sat_flag_d;
    logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                        sum_sat_q, sum_sat_d;

    logic signed [DIN_WIDTH-1:0] din_s;
    logic signed [ACC_WIDTH-1:0] seed;
    logic signed [ACC_WIDTH-1:0] add_sum;
    logic                        add_sat;
    logic                        accept;

    // Reset asserts immediately but releases two edges later, aligned to ap_clk.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) rst_sync_q <= 2'b11;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_i = rst_sync_q[1];
    assign din_s = bus.prod_din;
    assign seed  = ACC_WIDTH'(din_s);

    case_9_sat_add #(
        .DIN_WIDTH (DIN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .acc (acc_q),
        .din (din_s),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_flag_d = sat_flag_q;
        sum_d      = sum_q;
        sum_sat_d  = sum_sat_q;

        bus.prod_rdy = !rst_i && ((state_q == ACCUM) || bus.sum_rdy);
        bus.sum_vld  = (state_q == OUTPUT);
        bus.sum_dout = sum_q;
        bus.sum_sat  = sum_sat_q;
        bus.busy     = (cnt_q != '0) || (state_q == OUTPUT);
        accept       = bus.prod_vld && bus.prod_rdy;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        sum_d      = add_sum;
                        sum_sat_d  = sat_flag_q | add_sat;
                        acc_d      = '0;
                        cnt_d      = '0;
                        sat_flag_d = 1'b0;
                        state_d    = OUTPUT;
                    end else begin
                        acc_d      = add_sum;
                        cnt_d      = cnt_q + CNT_ONE;
                        sat_flag_d = sat_flag_q | add_sat;
                    end
                end
            end
            OUTPUT: begin
                if (bus.sum_rdy) begin
                    if (accept) begin
                        // A lone product cannot clamp, so the seeded frame starts clean.
                        if (FRAME_LEN == 1) begin
                            sum_d     = seed;
                            sum_sat_d = 1'b0;
                        end else begin
                            acc_d   = seed;
                            cnt_d   = CNT_ONE;
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge ap_clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_flag_q <= 1'b0;
            sum_q      <= '0;
            sum_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_flag_q <= sat_flag_d;
            sum_q      <= sum_d;
            sum_sat_q  <= sum_sat_d;
        end
    end
endmodule

// File: doc/case_9_prod_accum.md
Name: case_9_prod_accum

Overview:
- Downstream consumer of the case_9 signed 9s x 6s -> 10-bit multiplier output.
- Accumulates a fixed-length frame of signed products into a saturating accumulator.
- Presents each frame sum through a valid/ready handshake with backpressure.
- Sits between the multiplier datapath and the case_9 result writer.

Parameters:
- DIN_WIDTH, 10, width of the signed product input (matches the multiplier dout).
- ACC_WIDTH, 16, width of the signed accumulator and the sum output; must be at least DIN_WIDTH.
- FRAME_LEN, 8, number of products per frame; must be at least 1.
- CNT_WIDTH, 4, sample counter width; must satisfy 2^CNT_WIDTH > FRAME_LEN.

Ports:
- ap_clk  in  1  single clock; all state updates on its rising edge.
- ap_rst  in  1  reset, asynchronous and active-high.
- prod_din  in  DIN_WIDTH  signed product from the multiplier.
- prod_vld  in  1  prod_din valid.
- prod_rdy  out  1  block can accept prod_din this cycle.
- sum_dout  out  ACC_WIDTH  signed frame sum; held stable while sum_vld=1.
- sum_vld  out  1  frame sum available.
- sum_rdy  in  1  downstream accepts sum_dout.
- sum_sat  out  1  at least one clamp occurred in the presented frame; qualified by sum_vld.
- busy  out  1  a frame is partially accumulated (cnt != 0) or a sum is pending.

Behaviour:
- Interface: one clock; reset asynchronous, active-high.
- Reset (async assert, sync release on ap_clk):
  - state=ACCUM, acc=0, cnt=0, sat_flag=0.
  - sum_dout=0, sum_vld=0, sum_sat=0, prod_rdy=1 after release, busy=0.
- Handshake rules:
  - A product is accepted when prod_vld & prod_rdy.
  - A sum is taken when sum_vld & sum_rdy.
  - prod_rdy depends combinationally on state and sum_rdy only, never on prod_vld.
- Arithmetic:
  - next = acc + sign-extend(prod_din), computed at ACC_WIDTH+1 bits.
  - Clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets sat_flag, which is sticky for the current frame.
- State ACCUM:
  - prod_rdy=1, sum_vld=0.
  - On accept: acc<=clamped next, cnt<=cnt+1.
  - If cnt==FRAME_LEN-1 on accept: sum_dout<=clamped next, sum_sat<=sat_flag OR this clamp, acc<=0, cnt<=0, sat_flag<=0, go OUTPUT.
- State OUTPUT:
  - sum_vld=1; prod_rdy=sum_rdy.
  - sum_rdy=0: hold sum_dout and sum_sat; accept nothing.
  - sum_rdy=1 without accept: sum_vld falls next cycle, go ACCUM.
  - sum_rdy=1 with prod_vld: the accepted product seeds the next frame (acc<=sign-extend(prod_din), cnt<=1), so there is no bubble.
  - If FRAME_LEN==1, the seeded product instead completes the next frame immediately: reload sum_dout, stay in OUTPUT.
- Latency:
  - sum_vld rises the cycle after the FRAME_LEN-th accept.
  - Sustained throughput is 1 product per cycle when sum_rdy=1.
- Reset mid-frame or mid-OUTPUT discards the partial or pending sum. No output is produced for it.
- Products arriving while prod_rdy=0 are not consumed. The upstream holds them.

Decomposition:
- Package case_9_pkg:
  - Default DIN_WIDTH/ACC_WIDTH/FRAME_LEN constants.
  - State enum {ACCUM, OUTPUT}.
  - Saturation min/max constant functions.
- Sub-module case_9_sat_add:
  - Combinational signed add with width extension and clamp.
  - Outputs sum and sat bit.
  - Instantiated once.

Test Plan:
- 8 accepts of +3, sum_rdy=1 -> sum_dout=24, sum_sat=0, sum_vld high exactly 1 cycle, the cycle after the 8th accept.
- 8 accepts of -512 -> sum_dout=-4096, sum_sat=0.
- ACC_WIDTH=12, 8 accepts of +511:
  - clamp occurs at sample 5; sum_dout=2047, sum_sat=1.
  - next frame of 8 × 0 -> sum_dout=0, sum_sat=0 (flag cleared).
- Backpressure: frame of 1..8 (sum 36), sum_rdy low 5 cycles -> sum_dout=36 held, prod_rdy=0 throughout; release -> 1-cycle handoff.
- Back-to-back: continuous prod_vld=1 with value 1, sum_rdy=1 for 24 cycles -> three sums of 8, no prod_rdy low cycle.
- Assert ap_rst asynchronously after 5 accepts of +7 -> outputs zero immediately; next 8 × +2 -> sum_dout=16 (no residue of 35).
